// File: rtl/main_memory_responder.sv
// ============================================================================
// main_memory_responder : single-outstanding backing-store responder with a
// fixed access latency. Optional macro MEM_STATS_EN adds read/write counters.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module main_memory_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_busy
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]       o_rd_count,
  output logic [15:0]       o_wr_count
`endif
);

  localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      c_CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_access;
  logic                w_done;
  logic                w_in_range;
  logic [c_AW-1:0]     w_idx;

  assign w_accept   = (r_state == S_IDLE) && i_req_valid;
  assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_done     = (r_state == S_RESP) && i_resp_ready;
  // Full-width compare so out-of-range addresses are never aliased onto the array.
  assign w_in_range = ({1'b0, r_addr} < c_DEPTH_X);
  assign w_idx      = r_addr[c_AW-1:0];

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_busy       = (r_state != S_IDLE);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (w_access) w_next = S_RESP;
      S_RESP:  if (w_done)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= i_req_write;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_cnt   <= c_CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err <= ~w_in_range;
        if (!w_in_range) begin
          r_rdata <= '0;
        end else if (r_write) begin
          r_rdata <= r_wdata;
        end else begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Reset clears the whole image so an aborted writeback leaves no trace.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_access && r_write && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

`ifdef MEM_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_done) begin
      if (r_write) begin
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
      end else begin
        if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_memory_responder.sv
// ============================================================================
// tb_main_memory_responder : scoreboard bench for main_memory_responder.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_memory_responder;

  localparam int DEPTH = 32;
  localparam int LAT   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_req_valid = 1'b0;
  logic       o_req_ready;
  logic       i_req_write = 1'b0;
  logic [7:0] i_req_addr = '0;
  logic [7:0] i_req_wdata = '0;
  logic       o_resp_valid;
  logic       i_resp_ready = 1'b1;
  logic [7:0] o_resp_rdata;
  logic       o_resp_err;
  logic       o_busy;
`ifdef MEM_STATS_EN
  logic [15:0] o_rd_count;
  logic [15:0] o_wr_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] model [DEPTH];
  logic [9:0] sb [$];

  always #5 clk = ~clk;

  main_memory_responder #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .LATENCY(LAT)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_write  (i_req_write),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_busy       (o_busy)
`ifdef MEM_STATS_EN
    ,
    .o_rd_count   (o_rd_count),
    .o_wr_count   (o_wr_count)
`endif
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responses are popped just before the handshake edge.
  always @(negedge clk) begin
    if (rst_n && o_resp_valid && i_resp_ready) begin
      if (sb.size() == 0) begin
        check_value("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check_value("resp_rdata", {24'd0, o_resp_rdata}, {24'd0, e[7:0]});
        check_value("resp_err", {31'd0, o_resp_err}, {31'd0, e[8]});
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  task automatic drive(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int g;
    int lat;
    logic [7:0] e_data;
    logic       e_err;
    g = 0;
    while (!o_req_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 50) check_value("req_ready_timeout", 32'd0, 32'd1);
    if (int'(a) < DEPTH) begin
      e_err  = 1'b0;
      e_data = wr ? d : model[a[4:0]];
      if (wr) model[a[4:0]] = d;
    end else begin
      e_err  = 1'b1;
      e_data = 8'h00;
    end
    sb.push_back({wr, e_err, e_data});
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = a;
    i_req_wdata = d;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    check_value("busy_after_accept", {31'd0, o_busy}, 32'd1);
    lat = 0;
    while (!o_resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check_value("latency", lat, LAT);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (o_busy && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 50) check_value("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic wr, input logic [7:0] a, input logic [7:0] d);
    drive(wr, a, d);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    check_value("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check_value("rst_busy", {31'd0, o_busy}, 32'd0);
    check_value("rst_rdata", {24'd0, o_resp_rdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(1'b0, 8'd5, 8'h00);
    txn(1'b1, 8'd5, 8'hA7);
    txn(1'b0, 8'd5, 8'h00);
    txn(1'b0, 8'd40, 8'h00);
    txn(1'b0, 8'd5, 8'h00);
    txn(1'b0, 8'd255, 8'h00);
    txn(1'b1, 8'd31, 8'h3C);
    txn(1'b0, 8'd31, 8'h00);
    txn(1'b0, 8'd32, 8'h00);
    txn(1'b1, 8'd40, 8'h99);
    txn(1'b0, 8'd0, 8'h00);

    // Stalled response with a stray request that must be ignored.
    i_resp_ready = 1'b0;
    drive(1'b0, 8'd5, 8'h00);
    for (int k = 0; k < 4; k++) begin
      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_addr  = 8'd5;
      i_req_wdata = 8'hFF;
      @(posedge clk); #1;
      check_value("hold_valid", {31'd0, o_resp_valid}, 32'd1);
      check_value("hold_rdata", {24'd0, o_resp_rdata}, 32'hA7);
      check_value("hold_err", {31'd0, o_resp_err}, 32'd0);
      check_value("hold_req_ready", {31'd0, o_req_ready}, 32'd0);
    end
    i_req_valid  = 1'b0;
    i_resp_ready = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    check_value("stray_not_accepted", {31'd0, o_busy}, 32'd0);
    txn(1'b0, 8'd5, 8'h00);

    // Reset during WAIT of a write aborts it.
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_addr  = 8'd2;
    i_req_wdata = 8'h55;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    check_value("abort_busy", {31'd0, o_busy}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_value("abort_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check_value("abort_busy_clr", {31'd0, o_busy}, 32'd0);
    check_value("abort_req_ready", {31'd0, o_req_ready}, 32'd1);
    check_value("abort_rdata", {24'd0, o_resp_rdata}, 32'd0);
    check_value("abort_err", {31'd0, o_resp_err}, 32'd0);
    model_clear();
    check_value("abort_sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 8'd2, 8'h00);
    txn(1'b0, 8'd5, 8'h00);

    // Fresh reset, then 2 writes and 3 reads (one errored).
    rst_n = 1'b0;
    #2;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef MEM_STATS_EN
    check_value("rd_count_rst", {16'd0, o_rd_count}, 32'd0);
    check_value("wr_count_rst", {16'd0, o_wr_count}, 32'd0);
`endif
    txn(1'b1, 8'd7, 8'h11);
    txn(1'b1, 8'd30, 8'h6E);
    txn(1'b0, 8'd7, 8'h00);
    txn(1'b0, 8'd30, 8'h00);
    txn(1'b0, 8'd33, 8'h00);
`ifdef MEM_STATS_EN
    check_value("rd_count", {16'd0, o_rd_count}, 32'd3);
    check_value("wr_count", {16'd0, o_wr_count}, 32'd2);
`endif
    check_value("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Backing-store responder: the memory-side end of the cache-to-memory miss/writeback interface.
- Accepts single-word read (fill) and write (writeback) requests over a valid/ready handshake.
- Models a fixed access latency and returns each result over a valid/ready response channel.
- Sits below the cache controller and replaces its direct array indexing of main memory.

Parameters:
- ADDR_W, 8, request address width
- DATA_W, 8, data word width
- DEPTH, 32, number of memory words; valid addresses 0..DEPTH-1
- LATENCY, 3, cycles from request accept to resp_valid; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = write (writeback), 0 = read (fill)
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  DATA_W  read data, or echo of write data
resp_err  output  1  address out of range
busy  output  1  a request is in flight (state != IDLE)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - All DEPTH memory words cleared to 0.
  - req_ready=1 once state is IDLE.
  - Reset mid-operation aborts the request: no write is performed and no response is issued.
- FSM states IDLE, WAIT, RESP:
  - req_ready = (state==IDLE), combinational from state only.
  - IDLE: on an edge with req_valid&&req_ready, latch write/addr/wdata, load cnt=LATENCY-1, go to WAIT.
  - WAIT: if cnt!=0, cnt--. If cnt==0, perform the access, register the response, go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready=1 on an edge, then go to IDLE.
- Latency:
  - Request accepted at edge T; resp_valid rises after edge T+LATENCY.
  - The next request can be accepted no earlier than the edge after the response handshake. There is no pipelining: one outstanding request.
- Access:
  - Read: resp_rdata = mem[addr].
  - Write: mem[addr] <= wdata at the access edge; resp_rdata = wdata.
  - A read after a write to the same address returns the new data.
- Address range:
  - Addresses >= DEPTH perform no memory access; resp_err=1, resp_rdata=0.
  - Addresses are never wrapped or truncated.
- Handshake boundaries:
  - req_* inputs are ignored outside IDLE.
  - resp_ready while resp_valid=0 is ignored.
  - resp_ready held high still costs at least one RESP cycle.
- busy=1 in WAIT and RESP.

Optional Feature:
- Macro MEM_STATS_EN.
- When defined, adds two outputs:
  - rd_count (16 bits): increments when a read response handshake completes.
  - wr_count (16 bits): increments when a write response handshake completes.
  - Both saturate at 16'hFFFF; errored requests are counted too.
  - Both reset to 0.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then read addr 5 with resp_ready=1 -> req_ready=1 after reset; resp_valid rises 3 edges after accept; resp_rdata=0x00, resp_err=0.
- Write addr 5 data 0xA7, then read addr 5 -> write response echoes 0xA7; read returns 0xA7.
- Read addr 40 (>= DEPTH) -> resp_err=1, resp_rdata=0x00; the memory image is unchanged.
- Hold resp_ready=0 for 4 cycles after resp_valid -> resp_valid, resp_rdata and resp_err stay stable; req_ready=0 throughout; a new req_valid is ignored until after the handshake.
- Drop rst low during WAIT of a write to addr 2 with data 0x55 -> outputs clear immediately; a later read of addr 2 returns 0x00.
- With MEM_STATS_EN defined: 2 writes plus 3 reads, including one errored read -> wr_count=2, rd_count=3.
